// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit-side control logic.
// Holds the arbiter state encoding, baud constants and the round-robin search.
package uart_ctrl_pkg;

  localparam int CLK_HZ  = 50_000_000;
  localparam int BAUD    = 115200;
  localparam int BIT_CYC = 434;

  // Widest requester vector the round-robin helper handles.
  localparam int MAX_REQ = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    WAIT = ST_WAIT,
    HOLD = ST_HOLD,
    GAP  = ST_GAP
  } state_e;

  // First set bit of vec at or after ptr, wrapping modulo MAX_REQ.
  // Unused upper bits of vec must be zero so the wrap matches a narrower vector.
  function automatic logic [2:0] rr_next(input logic [2:0] ptr,
                                         input logic [MAX_REQ-1:0] vec);
    logic [2:0] idx;
    rr_next = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (vec[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational circular priority search: index of the first valid requester
// at or after ptr, plus a flag saying whether any requester is valid.
module uart_rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [IW-1:0]    ptr,
  input  logic [N_REQ-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             any
);

  always_comb begin
    idx = IW'(rr_next(3'(ptr), MAX_REQ'(vec)));
    any = |vec;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART byte transmitter among
// N_REQ requesters; bytes of different packets never interleave on the line.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int GAP_CYCLES   = 16,
  parameter int HOLD_TIMEOUT = 65535,
  localparam int GW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_done,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               err_timeout
);

  localparam int              GCW      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GCW-1:0]  GAP_LAST = GCW'(GAP_CYCLES);
  localparam logic [15:0]     TO_LAST  = 16'(HOLD_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic               last_q, last_d;
  logic [GCW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [15:0]        to_cnt_q, to_cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [GW-1:0]      pick_idx;
  logic               pick_any;
  logic [GW-1:0]      ptr_after;
  logic               load;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (GW)
  ) u_pick (
    .ptr (ptr_q),
    .vec (req_valid),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign ptr_after = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    last_d    = last_q;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (last_q) begin
            state_d   = GAP;
            ptr_d     = ptr_after;
            gap_cnt_d = '0;
          end else begin
            state_d  = HOLD;
            to_cnt_d = '0;
          end
        end
      end
      HOLD: begin
        if (req_valid[grant_q]) begin
          load    = 1'b1;
          state_d = SEND;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          ptr_d   = ptr_after;
          state_d = IDLE;
        end else if (to_cnt_q != 16'hFFFF) begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Byte and last flag are captured as the FSM enters SEND so that tx_data
    // is already valid in the tx_start cycle.
    if (load) begin
      tx_data_d = req_data[8*grant_d +: 8];
      last_d    = req_last[grant_d];
    end

    tx_start_d  = load;
    req_ready_d = load ? (N_REQ'(1) << grant_d) : '0;
    busy_d      = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      last_q      <= 1'b0;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations, then
// randomized requesters/transmitter, all compared each cycle to a timeline model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int TO  = 100;
  localparam int GW  = 2;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_done = 1'b0;
  logic [GW-1:0]  grant_id;
  logic           busy;
  logic           err_timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .GAP_CYCLES   (GAP),
    .HOLD_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: who holds the lock, whether a byte is on the wire, and the
  // absolute cycle numbers at which holding started and arbitration reopens.
  bit            m_locked, m_on_wire, m_last;
  int            m_ptr, m_owner, m_send_cyc, m_hold_from, m_idle_at;
  logic          e_start, e_busy, e_err;
  logic [N-1:0]  e_ready;
  logic [7:0]    e_data;
  logic [GW-1:0] e_grant;

  task automatic m_reset();
    m_locked = 0; m_on_wire = 0; m_last = 0;
    m_ptr = 0; m_owner = 0; m_send_cyc = 0; m_hold_from = 0; m_idle_at = 0;
    e_start = 0; e_busy = 0; e_err = 0; e_ready = '0; e_data = '0; e_grant = '0;
  endtask

  // From inputs seen in cycle c, derive the outputs required in cycle c+1.
  task automatic m_step(input int c);
    int w;
    w = -1;
    e_start = 0; e_err = 0; e_ready = '0;
    if (!m_locked) begin
      if (c >= m_idle_at)
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end else if (m_on_wire) begin
      if (c > m_send_cyc && tx_done) begin
        m_on_wire = 0;
        if (m_last) begin
          m_locked = 0; m_ptr = (m_owner + 1) % N; m_idle_at = c + 2 + GAP;
        end else begin
          m_hold_from = c + 1;
        end
      end
    end else if (req_valid[m_owner]) begin
      w = m_owner;
    end else if (c - m_hold_from == TO - 1) begin
      e_err = 1; m_locked = 0; m_ptr = (m_owner + 1) % N; m_idle_at = c + 1;
    end
    if (w >= 0) begin
      m_locked = 1; m_owner = w; m_on_wire = 1; m_send_cyc = c + 1; m_last = req_last[w];
      e_start = 1; e_ready = N'(1) << w; e_data = req_data[8*w +: 8]; e_grant = GW'(w);
    end
    e_busy = m_locked || (c + 1 < m_idle_at);
  endtask

  initial begin : compare
    m_reset();
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_reset();
      end else begin
        check("m_tx_start", tx_start, e_start);
        check("m_req_ready", req_ready, e_ready);
        check("m_tx_data", tx_data, e_data);
        check("m_grant_id", grant_id, e_grant);
        check("m_busy", busy, e_busy);
        check("m_err_timeout", err_timeout, e_err);
        m_step(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [7:0] d, input bit l);
    req_valid[i] = v;
    req_data[8*i +: 8] = d;
    req_last[i] = l;
  endtask

  // Waits wait_n cycles in WAIT, then pulses tx_done; returns in the cycle after.
  task automatic finish_byte(input int wait_n);
    repeat (wait_n) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int n);
    n = 0;
    do begin tick(); n++; end while (!tx_start && n < budget);
    check("start_seen", tx_start, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin tick(); n++; end while (busy && n < budget);
    check("idle_seen", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  logic [8:0] q [N][$];
  int         stall_until [N];
  int         tx_left, pkt_owner, len, n;

  initial begin : stim
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick(); tick();

    // Simultaneous req0 and req2 from ptr=0
    set_req(0, 1, 8'hA0, 1);
    set_req(2, 1, 8'hC2, 1);
    tick();
    check("c_start", tx_start, 1);
    check("c_ready0", req_ready, 4'b0001);
    check("c_data0", tx_data, 8'hA0);
    check("c_grant0", grant_id, 0);
    check("c_busy", busy, 1);
    req_valid[0] = 1'b0;
    finish_byte(3);
    wait_start(40, n);
    check("c_gap_latency", n, 18);
    check("c_ready2", req_ready, 4'b0100);
    check("c_data2", tx_data, 8'hC2);
    check("c_grant2", grant_id, 2);
    req_valid[2] = 1'b0;
    finish_byte(3);
    wait_idle(40);

    // Single byte from req0, gap length, stray tx_done in GAP and IDLE
    set_req(0, 1, 8'h22, 1);
    tick();
    check("b_start", tx_start, 1);
    check("b_ready", req_ready, 4'b0001);
    check("b_data", tx_data, 8'h22);
    check("b_grant", grant_id, 0);
    req_valid[0] = 1'b0;
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      tick();
      tx_done = (k == 5);
    end
    check("b_gap_busy", busy, 1);
    tick();
    check("b_idle_busy", busy, 0);
    check("b_idle_start", tx_start, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("b_stray_start", tx_start, 0);
    check("b_stray_busy", busy, 0);

    // Packet lock: req1 three bytes while req0 stays valid, ptr=1
    set_req(0, 1, 8'h55, 1);
    set_req(1, 1, 8'h11, 0);
    tick();
    check("d_grant_a", grant_id, 1);
    check("d_ready_a", req_ready, 4'b0010);
    check("d_data_a", tx_data, 8'h11);
    set_req(1, 1, 8'h33, 0);
    finish_byte(3);
    check("d_hold_nostart_b", tx_start, 0);
    tick();
    check("d_start_b", tx_start, 1);
    check("d_data_b", tx_data, 8'h33);
    check("d_grant_b", grant_id, 1);
    set_req(1, 1, 8'h34, 1);
    finish_byte(3);
    check("d_hold_nostart_c", tx_start, 0);
    tick();
    check("d_start_c", tx_start, 1);
    check("d_data_c", tx_data, 8'h34);
    check("d_grant_c", grant_id, 1);
    check("d_ready_c", req_ready, 4'b0010);
    req_valid[1] = 1'b0;
    finish_byte(3);
    wait_start(40, n);
    check("d_gap_latency", n, 18);
    check("d_grant_req0", grant_id, 0);
    check("d_data_req0", tx_data, 8'h55);
    req_valid[0] = 1'b0;
    finish_byte(3);
    wait_idle(40);

    // Hold timeout: req3 wins from ptr=1, stops mid-packet; req0 pending
    set_req(0, 1, 8'h66, 1);
    set_req(3, 1, 8'h77, 0);
    tick();
    check("e_grant3", grant_id, 3);
    check("e_ready3", req_ready, 4'b1000);
    check("e_data3", tx_data, 8'h77);
    req_valid[3] = 1'b0;
    finish_byte(3);
    repeat (99) tick();
    check("e_err_early", err_timeout, 0);
    check("e_busy_hold", busy, 1);
    tick();
    check("e_err_pulse", err_timeout, 1);
    check("e_busy_idle", busy, 0);
    tick();
    check("e_err_single", err_timeout, 0);
    check("e_start0", tx_start, 1);
    check("e_grant0", grant_id, 0);
    check("e_data0", tx_data, 8'h66);
    req_valid[0] = 1'b0;
    finish_byte(3);
    wait_idle(40);

    // Asynchronous reset while a byte is in flight
    set_req(1, 1, 8'h99, 1);
    tick();
    check("f_grant1", grant_id, 1);
    req_valid[1] = 1'b0;
    repeat (3) tick();
    #1 rstn = 1'b0;
    #1;
    check_reset_outputs("f_async");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    set_req(2, 1, 8'hAA, 1);
    tick();
    check("f_start2", tx_start, 1);
    check("f_grant2", grant_id, 2);
    check("f_data2", tx_data, 8'hAA);
    req_valid[2] = 1'b0;
    finish_byte(3);
    wait_idle(40);

    // Randomized traffic
    tx_left = 0;
    pkt_owner = -1;
    for (int i = 0; i < N; i++) stall_until[i] = 0;
    for (int t = 0; t < 3000; t++) begin
      tick();
      tx_done = 1'b0;
      if (tx_start) tx_left = $urandom_range(12, 1);
      else if (tx_left > 0) begin
        tx_left--;
        tx_done = (tx_left == 0);
      end else tx_done = ($urandom_range(15, 0) == 0);

      if (err_timeout) pkt_owner = -1;
      check("r_onehot_ready", 32'($onehot0(req_ready)), 1);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          if (q[i].size() == 0) begin
            check("r_ready_without_data", q[i].size(), 1);
          end else begin
            check("r_sb_data", tx_data, 32'(q[i][0][7:0]));
            if (pkt_owner >= 0) check("r_no_interleave", i, pkt_owner);
            pkt_owner = q[i][0][8] ? -1 : i;
            void'(q[i].pop_front());
            if ($urandom_range(7, 0) == 0) stall_until[i] = cyc + $urandom_range(150, 0);
          end
        end
        if (q[i].size() == 0 && $urandom_range(19, 0) == 0) begin
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) q[i].push_back({(b == len - 1), 8'($urandom)});
        end
        req_valid[i] = (q[i].size() != 0) && (cyc >= stall_until[i]);
        if (q[i].size() != 0) begin
          req_data[8*i +: 8] = q[i][0][7:0];
          req_last[i] = q[i][0][8];
        end else begin
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i] = 1'($urandom);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
